// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, error
// codes, default sync byte and the UART RX register offset.
package uart_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]  ERR_LENGTH  = 2'b10;
  localparam logic [1:0]  ERR_CSUM    = 2'b11;

  localparam logic [7:0]  MAGIC_DEFAULT  = 8'hA5;
  localparam logic [31:0] UART_RX_OFFSET = 32'h0000_0000;

  // States in which the loader wants bytes from the UART.
  function automatic logic is_polling(input state_e s);
    return s inside {SYNC, LEN0, LEN1, DATA, CSUM};
  endfunction

endpackage

// File: rtl/uart_loader_byte_fetch.sv
// UART RX poller: repeatedly reads the RX data register over a simple
// stb/ack bus while req is high, and presents one sample per read.
module uart_byte_fetch
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  // Handshake: stb_o stays high until ack_i; read data arrives the cycle
  // after ack_i, which is the sample cycle (sample_q). Dropping req aborts
  // any poll immediately because stb_o is gated by req.
  logic stb_q, stb_d;
  logic sample_q, sample_d;

  assign stb_o      = stb_q && req;
  assign we_o       = 1'b0;
  assign adr_o      = UART_RX_OFFSET;
  assign dat_o      = 32'h0;
  assign byte_valid = sample_q && req && dat_i[8];
  assign byte_data  = dat_i[7:0];

  always_comb begin
    stb_d    = stb_q;
    sample_d = 1'b0;
    if (!req) begin
      stb_d = 1'b0;
    end else if (stb_o && ack_i) begin
      stb_d    = 1'b0;
      sample_d = 1'b1;
    end else if (!stb_q) begin
      stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q    <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      stb_q    <= stb_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: waits for a sync byte, reads a little-endian word count,
// streams payload words into memory and verifies an XOR checksum.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              stb_o,
  output logic              we_o,
  output logic [31:0]       adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  input  logic              ack_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam logic [31:0] MAX_WORDS   = 32'd1 << ADDR_W;
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       idle_q, idle_d, idle_inc;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              req, timed, timeout, byte_valid;
  logic [7:0]        byte_data;
  logic [15:0]       len_n;

  uart_byte_fetch u_fetch (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .req        (req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i)
  );

  // SYNC polls but never times out; WRITE freezes the idle counter.
  assign req      = is_polling(state_q);
  assign timed    = req && (state_q != SYNC);
  assign idle_inc = idle_q + 32'd1;
  assign timeout  = timed && !byte_valid && (idle_inc == TIMEOUT_LIM);
  assign len_n    = {byte_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    csum_d     = csum_q;
    bcnt_d     = bcnt_q;
    err_code_d = err_code_q;
    if (timed)                 idle_d = byte_valid ? 32'd0 : idle_inc;
    else if (state_q == WRITE) idle_d = idle_q;
    else                       idle_d = 32'd0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = SYNC;
          len_d      = 16'd0;
          words_d    = 16'd0;
          addr_d     = '0;
          csum_d     = 8'h00;
          bcnt_d     = 2'd0;
          err_code_d = ERR_NONE;
        end
      end
      SYNC: if (byte_valid && byte_data == MAGIC) state_d = LEN0;
      LEN0: begin
        if (byte_valid) begin
          len_d[7:0] = byte_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (byte_valid) begin
          len_d = len_n;
          if (32'(len_n) > MAX_WORDS) begin
            state_d    = ERR;
            err_code_d = ERR_LENGTH;
          end else if (len_n == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          wdata_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          csum_d = csum_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_rdy) begin
          words_d = words_q + 16'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (words_q + 16'd1 == len_q) ? CSUM : DATA;
        end
      end
      CSUM: begin
        if (byte_valid) begin
          if (byte_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d    = ERR;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      words_q    <= 16'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      idle_q     <= 32'd0;
      csum_q     <= 8'h00;
      bcnt_q     <= 2'd0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idle_q     <= idle_d;
      csum_q     <= csum_d;
      bcnt_q     <= bcnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign mem_we       = (state_q == WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = is_polling(state_q) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a UART responder feeds byte streams, a memory
// responder applies backpressure, and a monitor scores writes and status.
module tb_uart_loader;

  localparam int ADDR_W = 14;
  localparam int TMO    = 1000;

  logic              clk;
  logic              sys_rst;
  logic              start;
  logic              stb_o, we_o;
  logic [31:0]       adr_o, dat_o, dat_i;
  logic              ack_i;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rdy;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  logic [47:0] exp_q[$];
  logic [7:0]  rx_q[$];
  int total, bad;
  int cyc, last_byte_cyc;
  int rdy_mode, bp_len, bp_cnt;

  uart_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .words_loaded(words_loaded)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // UART RX responder: random ack latency, random empty reads.
  initial begin
    ack_i = 1'b0;
    dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (ack_i) begin
        ack_i = 1'b0;
        if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          dat_i = {23'($urandom), 1'b1, rx_q.pop_front()};
          last_byte_cyc = cyc;
        end else begin
          dat_i = {23'($urandom), 1'b0, 8'($urandom)};
        end
      end else begin
        dat_i = {23'($urandom), 1'b0, 8'($urandom)};
        if (stb_o && !sys_rst && $urandom_range(0, 2) == 0) ack_i = 1'b1;
      end
    end
  end

  // memory ready driver: 0 always ready, 1 random, 2 hold low bp_len cycles
  initial begin
    mem_rdy = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: mem_rdy = 1'b1;
        1: mem_rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (mem_we && bp_cnt < bp_len) begin
            mem_rdy = 1'b0;
            bp_cnt++;
          end else begin
            mem_rdy = 1'b1;
          end
        end
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic              prev_we, prev_rdy, prev_rst;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [15:0]       prev_words;
    logic [47:0]       item;
    prev_we = 1'b0; prev_rdy = 1'b0; prev_rst = 1'b1;
    prev_addr = '0; prev_data = '0; prev_words = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!prev_rst && prev_we && prev_rdy)
        check("words_inc", 64'(words_loaded), 64'(prev_words + 16'd1));
      if (!prev_rst && prev_we && !prev_rdy && mem_we) begin
        check("hold_addr", 64'(mem_addr), 64'(prev_addr));
        check("hold_data", 64'(mem_wdata), 64'(prev_data));
      end
      if (!sys_rst && mem_we && mem_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h, want no write", mem_addr, mem_wdata);
        end else begin
          item = exp_q.pop_front();
          check("mem_write", {16'(mem_addr), mem_wdata}, 64'(item));
        end
      end
      if (!busy || mem_we) check("stb_quiet", 64'(stb_o), 64'd0);
      check("flags_excl", 64'(done && err), 64'd0);
      check("bus_const", 64'({we_o, adr_o}), 64'd0);
      check("dat_o_const", 64'(dat_o), 64'd0);
      prev_we = mem_we; prev_rdy = mem_rdy; prev_rst = sys_rst;
      prev_addr = mem_addr; prev_data = mem_wdata; prev_words = words_loaded;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_stb"}, 64'(stb_o), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_flags"}, 64'({busy, done, err, err_code}), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  // Reference frame builder: sync junk, magic, length, payload, checksum.
  task automatic send_frame(input int nw, input logic [15:0] len, input bit bad_cs);
    logic [7:0]  b, cs;
    logic [31:0] w;
    cs = 8'h00;
    for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      rx_q.push_back(b);
    end
    rx_q.push_back(8'hA5);
    rx_q.push_back(len[7:0]);
    rx_q.push_back(len[15:8]);
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom);
        w = w | (32'(b) << (8 * j));
        cs = cs ^ b;
        rx_q.push_back(b);
      end
      exp_q.push_back({16'(i), w});
    end
    rx_q.push_back(bad_cs ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  task automatic run_load(input string tag, input bit exp_done, input logic [1:0] exp_code,
                          input int exp_words);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_start_busy"}, 64'(busy), 64'd1);
    check({tag, "_start_clear"}, 64'({done, err, err_code, words_loaded}), 64'd0);
    n = 0;
    while (!(done || err) && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 30000) begin
      total++;
      bad++;
      $display("FAIL %s_wait: got no done/err after %0d cycles, want completion", tag, n);
    end
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(!exp_done));
    check({tag, "_err_code"}, 64'(err_code), 64'(exp_code));
    check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] s1 [0:11];
    int n, nw, diff;
    bit bad_cs;
    total = 0; bad = 0; last_byte_cyc = 0;
    rdy_mode = 0; bp_len = 0; bp_cnt = 0;
    sys_rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    sys_rst = 1'b0;

    // fixed stream, good checksum
    s1 = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 12; i++) rx_q.push_back(s1[i]);
    rx_q.push_back(8'h88);
    exp_q.push_back({16'd0, 32'h4433_2211});
    exp_q.push_back({16'd1, 32'h8877_6655});
    run_load("fixed_ok", 1'b1, 2'b00, 2);

    // same stream, wrong checksum
    for (int i = 0; i < 12; i++) rx_q.push_back(s1[i]);
    rx_q.push_back(8'h00);
    exp_q.push_back({16'd0, 32'h4433_2211});
    exp_q.push_back({16'd1, 32'h8877_6655});
    run_load("fixed_badcs", 1'b0, 2'b11, 2);

    // oversize lengths
    rx_q.push_back(8'hA5); rx_q.push_back(8'hFF); rx_q.push_back(8'hFF);
    run_load("len_ffff", 1'b0, 2'b10, 0);
    rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h40);
    run_load("len_4001", 1'b0, 2'b10, 0);

    // zero-length frame
    rx_q.push_back(8'hA5); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    run_load("len_zero", 1'b1, 2'b00, 0);

    // memory backpressure, short and longer than the idle timeout
    rdy_mode = 2; bp_len = 50; bp_cnt = 0;
    send_frame(2, 16'd2, 1'b0);
    run_load("bp50", 1'b1, 2'b00, 2);
    bp_len = 1200; bp_cnt = 0;
    send_frame(2, 16'd2, 1'b0);
    run_load("bp1200", 1'b1, 2'b00, 2);
    rdy_mode = 0;

    // silence after the first payload byte
    rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h00); rx_q.push_back(8'h11);
    run_load("timeout", 1'b0, 2'b01, 0);
    diff = cyc - last_byte_cyc;
    total++;
    if (diff < TMO || diff > TMO + 1) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d cycles after last byte, want %0d..%0d", diff, TMO, TMO + 1);
    end
    check("timeout_stb", 64'(stb_o), 64'd0);
    @(negedge clk);
    #1;
    check("timeout_stb_next", 64'(stb_o), 64'd0);
    check("timeout_err_sticky", 64'({err, err_code}), 64'b101);

    // random frames
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(1, 8);
      bad_cs = ($urandom_range(0, 3) == 0);
      send_frame(nw, 16'(nw), bad_cs);
      run_load($sformatf("rand%0d", f), !bad_cs, bad_cs ? 2'b11 : 2'b00, nw);
    end

    // reset in the middle of DATA: no writes may follow
    rx_q.push_back(8'hA5); rx_q.push_back(8'h03); rx_q.push_back(8'h00);
    rx_q.push_back(8'h5A); rx_q.push_back(8'h3C);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rx_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("mid_data_busy", 64'(busy), 64'd1);
    check("mid_data_wdata", 64'(mem_wdata[15:0]), 64'h3C5A);
    sys_rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("mid_reset");
    sys_rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_zero("post_reset");
    rx_q.delete();

    // recovery after reset
    send_frame(3, 16'd3, 1'b0);
    run_load("after_reset", 1'b1, 2'b00, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, memory word-address width; MAGIC, default 8'hA5, sync byte; TIMEOUT_CYC, default 100000000, idle cycles allowed between bytes after sync.
REQ-002 The design SHALL use one clock with a synchronous, active-high reset; no other clock or reset exists.
REQ-003 The ports SHALL be, in order (name  direction  width  meaning):
- sys_clk  in  1  clock
- sys_rst  in  1  sync active-high reset
- start  in  1  one-cycle load request
- stb_o  out  1  uart bus strobe
- we_o  out  1  uart bus write enable, always 0
- adr_o  out  32  uart bus address, always 0 (RX data register)
- dat_o  out  32  uart bus write data, always 0
- dat_i  in  32  uart read data; bit 8 = byte valid, [7:0] = byte
- ack_i  in  1  uart bus acknowledge
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdy  in  1  memory accepts write this cycle
- busy  out  1  load in progress
- done  out  1  sticky success flag
- err  out  1  sticky failure flag
- err_code  out  2  01 timeout, 10 length, 11 checksum
- words_loaded  out  16  words written so far

Function
REQ-004 Byte fetch SHALL hold stb_o high until ack_i, drop stb_o the next cycle, and sample dat_i in that cycle (dat_i is registered one cycle after ack_i).
REQ-005 A sample with dat_i[8]=0 SHALL be discarded, and a new poll SHALL start on the following cycle.
REQ-006 FSM states SHALL be IDLE, SYNC, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
REQ-007 Transitions:
- IDLE->SYNC on start; start SHALL be ignored outside IDLE, DONE and ERR.
- Start in DONE or ERR SHALL clear done, err, err_code and words_loaded, then enter SYNC.
REQ-008 In SYNC, bytes not equal to MAGIC SHALL be dropped, and the state SHALL wait indefinitely with no timeout.
REQ-009 LEN0 and LEN1 SHALL capture a 16-bit word count N, little-endian.
REQ-010 If N > 2**ADDR_W after LEN1: ERR with code 10. If N = 0: go directly to CSUM.
REQ-011 DATA SHALL assemble 4 bytes little-endian (first byte -> [7:0]), then enter WRITE.
REQ-012 WRITE SHALL hold mem_we=1 with stable mem_addr and mem_wdata until a cycle with mem_rdy=1. In that cycle it SHALL increment words_loaded and the address, then go to DATA, or to CSUM when words_loaded reaches N.
REQ-013 mem_addr SHALL start at 0 and increment by 1 per accepted word; no wrap occurs because REQ-010 bounds N.
REQ-014 Checksum SHALL be the XOR of all payload bytes, initialised to 8'h00; length bytes are excluded.
REQ-015 In CSUM, a byte equal to the checksum SHALL lead to DONE; any other byte SHALL lead to ERR with code 11.
REQ-016 In LEN0, LEN1, DATA and CSUM, a 32-bit idle counter SHALL clear on every valid byte. Reaching TIMEOUT_CYC SHALL force ERR with code 01.
REQ-017 The idle counter SHALL be frozen in WRITE, so memory backpressure never times out.
REQ-018 busy SHALL be 1 in every state except IDLE, DONE and ERR. done and err SHALL be mutually exclusive.
REQ-019 stb_o SHALL be 0 in IDLE, WRITE, DONE and ERR. Entering ERR mid-poll SHALL drop stb_o on the next cycle.

Reset
REQ-020 On sys_rst, the FSM SHALL enter IDLE and all outputs SHALL be 0, including stb_o, mem_we, words_loaded and err_code.
REQ-021 On sys_rst, the checksum, byte counter and idle counter SHALL be cleared.
REQ-022 Reset asserted mid-load SHALL abort within one cycle, with no further mem_we.

Structure
REQ-023 A shared package uart_loader_pkg SHALL hold the state enum, the err_code constants, the default MAGIC value and the UART RX register offset.
REQ-024 The bus poller SHALL be one sub-module, uart_byte_fetch, with ports req, byte_valid and byte_data, and it SHALL own the stb/ack handshake.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Stream 00 A5 02 00 11 22 33 44 55 66 77 88 and checksum 88, mem_rdy=1 -> words 0x44332211 @0 and 0x88776655 @1, done=1, words_loaded=2.
- Same stream with checksum 00 -> err=1, err_code=11, both words written.
- Length bytes FF FF with ADDR_W=14 -> err_code=10, no mem_we.
- A5 01 00 11 then silence, TIMEOUT_CYC=1000 -> err_code=01 at 1000 idle cycles, stb_o low the next cycle.
- mem_rdy held low for 50 cycles during WRITE -> mem_we and data stable, no timeout, write completes on the first mem_rdy=1.
- A5 00 00 00 -> done=1, words_loaded=0; sys_rst pulsed mid-DATA -> all outputs 0 on the next cycle.
